// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common data bus arbiter.
// Each execution unit pushes {tag, data} into its own small FIFO. A
// round-robin arbiter then pops one head per cycle onto a registered CDB.
// Optional build macro: CDB_ARB_STATS_EN enables the stall_count
// contention counter. When it is undefined, stall_count is tied to 0.
// NUM_SRC must be >= 2. FIFO_DEPTH must be a power of two and >= 2.
module cdb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int IQ_DEPTH   = 16,
    parameter int ID_WIDTH   = $clog2(IQ_DEPTH),
    parameter int NUM_SRC    = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          flush,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC*ID_WIDTH-1:0]   src_tag,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic                          cdb_valid,
    output logic [ID_WIDTH-1:0]           cdb_tag,
    output logic [DATA_WIDTH-1:0]         cdb_data,
    output logic [$clog2(NUM_SRC)-1:0]    cdb_src,
    output logic [31:0]                   stall_count
);

    localparam int SRC_W   = $clog2(NUM_SRC);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = ID_WIDTH + DATA_WIDTH;

    logic [ENTRY_W-1:0] mem    [NUM_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr [NUM_SRC];
    logic [PTR_W-1:0]   wr_ptr [NUM_SRC];
    logic [CNT_W-1:0]   count  [NUM_SRC];
    logic [SRC_W-1:0]   rr_ptr;

    logic [NUM_SRC-1:0] req_p0;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic               gnt_vld_p0;
    logic [SRC_W-1:0]   gnt_idx_p0;
    logic [ENTRY_W-1:0] head_p0;

    // ---- stage p0: FIFO occupancy -> ready, request, push (pre-edge state only)
    // Ready and requests look only at occupancy before the edge, so a full FIFO refuses a same-cycle push.
    always_comb begin
        req_p0    = '0;
        src_ready = '0;
        push      = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            req_p0[i]    = (count[i] != '0);
            src_ready[i] = (count[i] < CNT_W'(FIFO_DEPTH)) && !flush && resetn;
            push[i]      = src_valid[i] && src_ready[i];
        end
    end

    // Round-robin pick: the first requester at or after rr_ptr, wrapping around.
    always_comb begin
        gnt_vld_p0 = 1'b0;
        gnt_idx_p0 = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!gnt_vld_p0 && req_p0[SRC_W'((int'(rr_ptr) + k) % NUM_SRC)]) begin
                gnt_vld_p0 = 1'b1;
                gnt_idx_p0 = SRC_W'((int'(rr_ptr) + k) % NUM_SRC);
            end
        end
    end

    // Pop the granted head. Flush suppresses the pop because it clears everything anyway.
    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pop[i] = gnt_vld_p0 && (gnt_idx_p0 == SRC_W'(i)) && !flush;
        end
    end

    assign head_p0 = mem[gnt_idx_p0][rd_ptr[gnt_idx_p0]];

    // FIFO pointers and occupancy. A push and a pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                count[i]  <= '0;
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
        end
    end

    // FIFO storage. This is data only, so it has no reset. Push is already gated by resetn and flush.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= {src_tag[i*ID_WIDTH +: ID_WIDTH],
                                      src_data[i*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    // ---- stage p1: registered CDB broadcast and round-robin pointer
    // With no grant, valid drops and tag/data/src keep their last values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
        end else if (flush) begin
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
        end else if (gnt_vld_p0) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= head_p0[ENTRY_W-1 -: ID_WIDTH];
            cdb_data  <= head_p0[DATA_WIDTH-1:0];
            cdb_src   <= gnt_idx_p0;
            rr_ptr    <= (gnt_idx_p0 == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx_p0 + 1'b1;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

`ifdef CDB_ARB_STATS_EN
    logic [31:0] req_cnt;
    logic [31:0] stall_q;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    // Count the requesters competing this cycle.
    always_comb begin
        req_cnt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            req_cnt = req_cnt + 32'(req_p0[i]);
        end
    end

    // Every requester that is not granted is charged one stall. Only reset clears the counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_q <= '0;
        end else if (!flush && (req_cnt >= 32'd2)) begin
            stall_q <= sat_add32(stall_q, req_cnt - 32'd1);
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

endmodule
